// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and defaults
// for the UART TX round-robin arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int          DEF_N_REQ      = 4;
    localparam int          DEF_GAP_CYCLES = 2;
    localparam logic [31:0] DEF_TIMEOUT    = 32'd100_000;
    localparam int          BYTE_W         = 8;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner search,
// starting one above the last granted index.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    int w_k;

    // Walk offsets high to low so the nearest offset is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_k     = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_k = (int'(i_last) + i) % N_REQ;
            if (i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX engine.
// Optional SEND watchdog enabled by UART_TX_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ          = DEF_N_REQ,
    parameter int          IDX_W          = 2,
    parameter int          GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                    CLK,
    input  logic                    Rstn,
    input  logic [N_REQ-1:0]        Req,
    input  logic [BYTE_W*N_REQ-1:0] Req_Data,
    output logic [N_REQ-1:0]        Ack,
    output logic                    Busy,
    output logic [IDX_W-1:0]        Grant_Idx,
`ifdef UART_TX_TIMEOUT_EN
    output logic                    Timeout_Err,
`endif
    input  logic                    TX_Done_Sig,
    output logic                    TX_En_Sig,
    output logic [BYTE_W-1:0]       TX_Data
);

    arb_state_t         r_state, w_state_n;
    logic               r_en, w_en_n;
    logic [BYTE_W-1:0]  r_data, w_data_n;
    logic [N_REQ-1:0]   r_ack, w_ack_n;
    logic               r_busy, w_busy_n;
    logic [IDX_W-1:0]   r_gidx, w_gidx_n;
    logic [31:0]        r_gap_cnt, w_gap_n;
    logic               w_fin;
    logic               w_valid;
    logic [IDX_W-1:0]   w_win;
`ifdef UART_TX_TIMEOUT_EN
    logic [31:0]        r_to_cnt, w_to_n;
    logic               r_to_err, w_err_n;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (Req),
        .i_last  (r_gidx),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    // State and registered outputs; reset kills any in-flight byte.
    always_ff @(posedge CLK or negedge Rstn) begin
        if (!Rstn) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_data    <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_gidx    <= IDX_W'(N_REQ - 1);
            r_gap_cnt <= '0;
`ifdef UART_TX_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_to_err  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_en      <= w_en_n;
            r_data    <= w_data_n;
            r_ack     <= w_ack_n;
            r_busy    <= w_busy_n;
            r_gidx    <= w_gidx_n;
            r_gap_cnt <= w_gap_n;
`ifdef UART_TX_TIMEOUT_EN
            r_to_cnt  <= w_to_n;
            r_to_err  <= w_err_n;
`endif
        end
    end

    // Next-state: grant in IDLE, hold in SEND, pace bytes in GAP.
    always_comb begin
        w_state_n = r_state;
        w_en_n    = r_en;
        w_data_n  = r_data;
        w_ack_n   = '0;
        w_busy_n  = r_busy;
        w_gidx_n  = r_gidx;
        w_gap_n   = r_gap_cnt;
        w_fin     = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
        w_to_n    = r_to_cnt;
        w_err_n   = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_gidx_n  = w_win;
                    w_data_n  = Req_Data[int'(w_win)*BYTE_W +: BYTE_W];
                    w_en_n    = 1'b1;
                    w_busy_n  = 1'b1;
                    w_state_n = SEND;
`ifdef UART_TX_TIMEOUT_EN
                    w_to_n    = '0;
`endif
                end
            end
            SEND: begin
                w_fin = TX_Done_Sig;
`ifdef UART_TX_TIMEOUT_EN
                w_to_n = r_to_cnt + 32'd1;
                if (!TX_Done_Sig &&
                    r_to_cnt == TIMEOUT_CYCLES - 32'd1) begin
                    w_fin   = 1'b1;
                    w_err_n = 1'b1;
                end
`endif
                if (w_fin) begin
                    w_en_n  = 1'b0;
                    w_ack_n = N_REQ'(1) << r_gidx;
                    w_gap_n = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_n = GAP;
                    end else begin
                        w_state_n = IDLE;
                        w_busy_n  = 1'b0;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == 32'(GAP_CYCLES - 1)) begin
                    w_state_n = IDLE;
                    w_busy_n  = 1'b0;
                end else begin
                    w_gap_n = r_gap_cnt + 32'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_en_n    = 1'b0;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign Ack       = r_ack;
    assign Busy      = r_busy;
    assign Grant_Idx = r_gidx;
    assign TX_En_Sig = r_en;
    assign TX_Data   = r_data;
`ifdef UART_TX_TIMEOUT_EN
    assign Timeout_Err = r_to_err;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order,
// data latching, gap pacing, reset and optional watchdog.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        Rstn = 1'b0;
    logic [3:0]  Req = '0;
    logic [31:0] Req_Data = '0;
    logic [3:0]  Ack;
    logic        Busy;
    logic [1:0]  Grant_Idx;
    logic        TX_Done_Sig = 1'b0;
    logic        TX_En_Sig;
    logic [7:0]  TX_Data;
`ifdef UART_TX_TIMEOUT_EN
    logic        Timeout_Err;
`endif

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .N_REQ          (4),
        .IDX_W          (2),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (32'd20)
    ) dut (
        .CLK         (CLK),
        .Rstn        (Rstn),
        .Req         (Req),
        .Req_Data    (Req_Data),
        .Ack         (Ack),
        .Busy        (Busy),
        .Grant_Idx   (Grant_Idx),
`ifdef UART_TX_TIMEOUT_EN
        .Timeout_Err (Timeout_Err),
`endif
        .TX_Done_Sig (TX_Done_Sig),
        .TX_En_Sig   (TX_En_Sig),
        .TX_Data     (TX_Data)
    );

    always #10 CLK = ~CLK;

    task automatic wait_en(input string nm);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (TX_En_Sig === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_en_timeout: TX_En_Sig=%b want 1", nm, TX_En_Sig);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Rstn = 1'b0;
        Req = '0;
        TX_Done_Sig = 1'b0;
        @(negedge CLK);
        Rstn = 1'b1;
    endtask

    task automatic test_reset();
        Rstn = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({TX_En_Sig, TX_Data, Ack, Busy, Grant_Idx} !== {1'b0, 8'h00, 4'b0, 1'b0, 2'd3}) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b data=%h ack=%b busy=%b gidx=%0d want 0 00 0000 0 3",
                     TX_En_Sig, TX_Data, Ack, Busy, Grant_Idx);
        end
        Rstn = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (Ack !== 4'b0 || TX_En_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_ignored: ack=%b en=%b want 0000 0", Ack, TX_En_Sig);
        end
    endtask

    task automatic test_single();
        Req = 4'b0001;
        Req_Data = 32'h0000_000A;
        @(negedge CLK);
        n_checks++;
        if ({TX_En_Sig, TX_Data, Busy, Grant_Idx} !== {1'b1, 8'h0A, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL single_grant: en=%b data=%h busy=%b gidx=%0d want 1 0a 1 0",
                     TX_En_Sig, TX_Data, Busy, Grant_Idx);
        end
        Req = 4'b0000;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (TX_En_Sig !== 1'b1 || Ack !== 4'b0) begin
            n_fail++;
            $display("FAIL single_hold: en=%b ack=%b want 1 0000", TX_En_Sig, Ack);
        end
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({Ack, TX_En_Sig, Busy} !== {4'b0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b en=%b busy=%b want 0001 0 1", Ack, TX_En_Sig, Busy);
        end
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        n_checks++;
        if (Ack !== 4'b0 || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_done_ignored: ack=%b busy=%b want 0000 1", Ack, Busy);
        end
        @(negedge CLK);
        n_checks++;
        if (Busy !== 1'b0 || Ack !== 4'b0) begin
            n_fail++;
            $display("FAIL gap_end_busy: busy=%b ack=%b want 0 0000", Busy, Ack);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A};
        logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        Req_Data = {8'h0D, 8'h0C, 8'h0B, 8'h0A};
        Req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_en("rr");
            n_checks++;
            if (TX_Data !== exp_d[n]) begin
                n_fail++;
                $display("FAIL rr_data_%0d: got %h want %h", n, TX_Data, exp_d[n]);
            end
            repeat (9) @(negedge CLK);
            TX_Done_Sig = 1'b1;
            @(negedge CLK);
            TX_Done_Sig = 1'b0;
            n_checks++;
            if (Ack !== exp_a[n]) begin
                n_fail++;
                $display("FAIL rr_ack_%0d: got %b want %b", n, Ack, exp_a[n]);
            end
        end
        Req = 4'b0000;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_wrap();
        Req_Data = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        Req = 4'b0100;
        wait_en("wrap_a");
        n_checks++;
        if (Grant_Idx !== 2'd2 || TX_Data !== 8'h2C) begin
            n_fail++;
            $display("FAIL wrap_first: gidx=%0d data=%h want 2 2c", Grant_Idx, TX_Data);
        end
        Req = 4'b0000;
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        Req = 4'b0101;
        wait_en("wrap_b");
        n_checks++;
        if (Grant_Idx !== 2'd0 || TX_Data !== 8'h0A) begin
            n_fail++;
            $display("FAIL wrap_next: gidx=%0d data=%h want 0 0a", Grant_Idx, TX_Data);
        end
        Req = 4'b0000;
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        n_checks++;
        if (Ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_ack: got %b want 0001", Ack);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_data_latch();
        Req_Data = 32'h0000_000A;
        Req = 4'b0001;
        wait_en("latch");
        Req_Data[7:0] = 8'hFF;
        Req = 4'b0000;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (TX_Data !== 8'h0A || TX_En_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_hold: data=%h en=%b want 0a 1", TX_Data, TX_En_Sig);
        end
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        n_checks++;
        if (Ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL latch_ack: got %b want 0001", Ack);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset_mid_send();
        bit bad = 0;
        Req_Data = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        Req = 4'b0010;
        wait_en("rst");
        Req = 4'b0000;
        repeat (2) @(negedge CLK);
        #3 Rstn = 1'b0;
        #1;
        n_checks++;
        if ({TX_En_Sig, Ack, Grant_Idx, Busy} !== {1'b0, 4'b0, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_send: en=%b ack=%b gidx=%0d busy=%b want 0 0000 3 0",
                     TX_En_Sig, Ack, Grant_Idx, Busy);
        end
        @(negedge CLK);
        Rstn = 1'b1;
        TX_Done_Sig = 1'b1;
        @(negedge CLK);
        TX_Done_Sig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (Ack !== 4'b0 || TX_En_Sig !== 1'b0) bad = 1;
            @(negedge CLK);
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_no_ack: ack=%b en=%b want 0000 0 throughout", Ack, TX_En_Sig);
        end
    endtask

`ifdef UART_TX_TIMEOUT_EN
    task automatic test_timeout();
        bit early = 0;
        do_reset();
        Req_Data = {8'h3D, 8'h2C, 8'h1B, 8'h0A};
        Req = 4'b0100;
        wait_en("to");
        Req = 4'b0000;
        for (int i = 1; i < 20; i++) begin
            @(negedge CLK);
            if (TX_En_Sig !== 1'b1 || Timeout_Err !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL to_early: en/err changed before cycle 20 (en=%b err=%b)",
                     TX_En_Sig, Timeout_Err);
        end
        @(negedge CLK);
        n_checks++;
        if ({TX_En_Sig, Timeout_Err, Ack} !== {1'b0, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL to_fire: en=%b err=%b ack=%b want 0 1 0100",
                     TX_En_Sig, Timeout_Err, Ack);
        end
        @(negedge CLK);
        n_checks++;
        if (Timeout_Err !== 1'b0 || Ack !== 4'b0) begin
            n_fail++;
            $display("FAIL to_pulse: err=%b ack=%b want 0 0000", Timeout_Err, Ack);
        end
        repeat (3) @(negedge CLK);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_data_latch();
        test_reset_mid_send();
`ifdef UART_TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX byte engine between N_REQ independent byte producers, each of the same kind as the periodic data-control sources.
- Grants the requesters round-robin and drives the engine's TX_En_Sig / TX_Data. It holds enable until TX_Done_Sig arrives, then returns a one-cycle Ack to the winning requester.
- Sits between the producers and the UART TX module, and replaces direct wiring of any single producer to the engine.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must equal clog2(N_REQ).
- GAP_CYCLES, 2, idle cycles with TX_En_Sig low between consecutive bytes (0 allowed).
- TIMEOUT_CYCLES, 32'd100_000, SEND-state watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  system clock, 50 MHz.
- Rstn  in  1  asynchronous active-low reset.
- Req  in  N_REQ  level request per requester; bit r high means Req_Data slice r is valid.
- Req_Data  in  8*N_REQ  byte of requester r in bits [8r+7:8r].
- Ack  out  N_REQ  one-cycle pulse to the requester whose byte completed.
- Busy  out  1  high in SEND and GAP.
- Grant_Idx  out  IDX_W  index of the current or last granted requester.
- TX_Done_Sig  in  1  completion pulse from the UART TX engine.
- TX_En_Sig  out  1  level enable to the UART TX engine.
- TX_Data  out  8  byte to the UART TX engine.

Behaviour:
- Reset is Rstn, asynchronous, active-low; clock is CLK.
- Reset values:
  - State IDLE.
  - TX_En_Sig=0, TX_Data=8'h00, Ack=0, Busy=0.
  - Grant_Idx=N_REQ-1, so requester 0 has top priority first.
  - Gap and timeout counters at 0.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If Req is nonzero at edge k, pick the first set bit searching upward from Grant_Idx+1, wrapping modulo N_REQ.
  - At edge k: Grant_Idx <= winner, TX_Data <= winner's Req_Data slice, TX_En_Sig <= 1, Busy <= 1, go to SEND.
  - Latency from sampled Req to TX_En_Sig high is 1 cycle.
- SEND:
  - TX_En_Sig and TX_Data are held constant. Changes on Req or Req_Data are ignored; data is latched at grant.
  - On TX_Done_Sig: TX_En_Sig <= 0 and Ack[Grant_Idx] <= 1 for exactly one cycle.
  - Then go to GAP if GAP_CYCLES > 0; otherwise go to IDLE with Busy <= 0.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE with Busy <= 0.
  - Req is not sampled during GAP.
- Requester rules:
  - A requester must drop Req in the cycle after its Ack, or present a new byte.
  - A still-high Req after Ack counts as a new request. It wins again only if no other requester is pending.
- Boundary conditions:
  - TX_Done_Sig while in IDLE or GAP: ignored, and no Ack is issued.
  - Req dropped mid-SEND: the byte still completes and Ack still pulses.
  - All N_REQ requests high continuously: grants follow the strict sequence 0,1,2,3,0,…
  - Grant_Idx wraps from N_REQ-1 to 0.
  - Rstn asserted mid-SEND: TX_En_Sig drops immediately (asynchronous) and the in-flight byte gets no Ack.

Optional Feature:
- Macro: UART_TX_TIMEOUT_EN.
- With the macro:
  - Adds output Timeout_Err (1 bit, reset 0).
  - A 32-bit counter runs while in SEND and clears on entry to SEND.
  - If it reaches TIMEOUT_CYCLES-1 without TX_Done_Sig: TX_En_Sig <= 0, Timeout_Err pulses for 1 cycle, Ack[Grant_Idx] pulses for 1 cycle (the byte is dropped), then go to GAP.
  - TX_Done_Sig and timeout in the same cycle: Done wins and no error is flagged.
- Without the macro: no counter and no port; SEND waits indefinitely.

Decomposition:
- Package uart_arb_pkg holds:
  - State encoding: IDLE=2'd0, SEND=2'd1, GAP=2'd2.
  - Default constants: N_REQ, GAP_CYCLES, TIMEOUT_CYCLES.
  - The byte width constant, 8.
- Sub-module rr_picker: purely combinational. Inputs are Req and the last index; outputs are a valid flag and the winner index.

Test Plan:
- Reset then Req=4'b0001, Req_Data[7:0]=8'h0A: TX_En_Sig high 1 cycle later with TX_Data=8'h0A. On a TX_Done_Sig pulse, Ack=4'b0001 for 1 cycle, Busy low after 2 GAP cycles.
- Req=4'b1111 held, Req_Data={8'h0D,8'h0C,8'h0B,8'h0A}, TX_Done_Sig 10 cycles after each enable: TX_Data sequence 0A,0B,0C,0D,0A and Ack order 1,2,4,8,1.
- Grant to requester 2, then Req=4'b0101 in GAP: next grant is requester 0, checking wrap from 2→3→0.
- In SEND, change Req_Data[7:0] to 8'hFF and drop Req[0]: TX_Data stays 8'h0A and Ack[0] still pulses after TX_Done_Sig.
- Assert Rstn low mid-SEND: TX_En_Sig=0, Ack=0, Grant_Idx=3 immediately; no Ack after release.
- With UART_TX_TIMEOUT_EN and TIMEOUT_CYCLES=20, never assert TX_Done_Sig: at the 20th SEND cycle TX_En_Sig drops and Timeout_Err and Ack[winner] each pulse for 1 cycle.
